// File: rtl/hwpe_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among N_REQ streamer ports,
// with an in-order ID FIFO steering responses. Optional macro: HWPE_TCDM_ARB_STALL_CNT_EN.
module hwpe_tcdm_arbiter #(
  parameter int N_REQ           = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_REQ-1:0]                 req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      add_i,
  input  logic [N_REQ-1:0]                 wen_i,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0]  be_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]      wdata_i,
  output logic [N_REQ-1:0]                 gnt_o,
  output logic [N_REQ-1:0]                 r_valid_o,
  output logic [N_REQ*DATA_WIDTH-1:0]      r_rdata_o,
  output logic                             m_req_o,
  output logic [ADDR_WIDTH-1:0]            m_add_o,
  output logic                             m_wen_o,
  output logic [DATA_WIDTH/8-1:0]          m_be_o,
  output logic [DATA_WIDTH-1:0]            m_wdata_o,
  input  logic                             m_gnt_i,
  input  logic                             m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            m_r_rdata_i,
  output logic                             err_o,
  output logic [15:0]                      stall_cnt_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] DEPTH = CW'(MAX_OUTSTANDING);

  logic [N_REQ-1:0][ADDR_WIDTH-1:0] add_a;
  logic [N_REQ-1:0][BW-1:0]         be_a;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] wdata_a;

  logic [IW-1:0] prio, winner, prio_next, head;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          full, empty, accept, pop;
  int            idx;

  assign add_a   = add_i;
  assign be_a    = be_i;
  assign wdata_a = wdata_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // First requester at or after prio, wrapping; scanned highest offset first
  // so the lowest offset wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(prio) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[IW'(idx)]) winner = IW'(idx);
    end
  end

  assign prio_next = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);

  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);
  assign head  = fifo_q[rd_ptr];

  // Handshake: a transfer happens in the cycle m_req_o and m_gnt_i are both
  // high; full blocks the request even when a pop frees a slot that cycle.
  assign m_req_o   = (|req_i) & ~full & ~rst_i;
  assign accept    = m_req_o & m_gnt_i;
  assign pop       = m_r_valid_i & ~empty & ~rst_i;
  assign m_add_o   = add_a[winner];
  assign m_wen_o   = wen_i[winner];
  assign m_be_o    = be_a[winner];
  assign m_wdata_o = wdata_a[winner];
  assign r_rdata_o = {N_REQ{m_r_rdata_i}};

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (accept) gnt_o[winner] = 1'b1;
    if (pop)    r_valid_o[head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wr_ptr] <= winner;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_o  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
        prio   <= prio_next;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (accept && !pop)      cnt <= cnt + CW'(1);
      else if (!accept && pop) cnt <= cnt - CW'(1);
      if (m_r_valid_i && empty) err_o <= 1'b1;
    end
  end

`ifdef HWPE_TCDM_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((|req_i) && !accept && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_tcdm_arbiter.sv
// Directed bench for hwpe_tcdm_arbiter: round-robin order, stall priority,
// FIFO full blocking, push/pop, stray response and the optional stall counter.
module tb_hwpe_tcdm_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [N-1:0]         req_i;
  logic [N*AW-1:0]      add_i;
  logic [N-1:0]         wen_i;
  logic [N*(DW/8)-1:0]  be_i;
  logic [N*DW-1:0]      wdata_i;
  logic [N-1:0]         gnt_o;
  logic [N-1:0]         r_valid_o;
  logic [N*DW-1:0]      r_rdata_o;
  logic                 m_req_o;
  logic [AW-1:0]        m_add_o;
  logic                 m_wen_o;
  logic [DW/8-1:0]      m_be_o;
  logic [DW-1:0]        m_wdata_o;
  logic                 m_gnt_i;
  logic                 m_r_valid_i;
  logic [DW-1:0]        m_r_rdata_i;
  logic                 err_o;
  logic [15:0]          stall_cnt_o;

  int checks = 0;
  int errors = 0;

  hwpe_tcdm_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
    .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i),
    .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] addr_of(input int k);
    return 32'h0000_1000 + 32'(k) * 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                       input logic [DW-1:0] rdata);
    @(negedge clk_i);
    req_i       = req;
    m_gnt_i     = gnt;
    m_r_valid_i = rv;
    m_r_rdata_i = rdata;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      add_i[k*AW +: AW]   = addr_of(k);
      wdata_i[k*DW +: DW] = 32'hD000_0000 | 32'(k);
      be_i[k*4 +: 4]      = 4'hF;
      wen_i[k]            = k[0];
    end

    // Reset: outputs gated even with all inputs active
    drive(4'b1111, 1'b1, 1'b1, 32'h0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_mreq", m_req_o, 0);
    chk("rst_rvalid", r_valid_o, 0);
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b0;
    #1;
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_cnt_o, 0);

    // Round-robin with responses one cycle behind each grant
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    chk("rr_gnt0", gnt_o, 4'b0001);
    chk("rr_add0", m_add_o, addr_of(0));
    chk("rr_wen0", m_wen_o, 0);
    drive(4'b1111, 1'b1, 1'b1, 32'hA0);
    chk("rr_gnt1", gnt_o, 4'b0010);
    chk("rr_rv0", r_valid_o, 4'b0001);
    chk("rr_rdata0", r_rdata_o[0 +: DW], 32'hA0);
    chk("rr_wen1", m_wen_o, 1);
    drive(4'b1111, 1'b1, 1'b1, 32'hA1);
    chk("rr_gnt2", gnt_o, 4'b0100);
    chk("rr_rv1", r_valid_o, 4'b0010);
    chk("rr_rdata1", r_rdata_o[DW +: DW], 32'hA1);
    drive(4'b1111, 1'b1, 1'b1, 32'hA2);
    chk("rr_gnt3", gnt_o, 4'b1000);
    chk("rr_rv2", r_valid_o, 4'b0100);
    chk("rr_wdata3", m_wdata_o, 32'hD000_0003);
    drive(4'b1111, 1'b1, 1'b1, 32'hA3);
    chk("rr_gnt0b", gnt_o, 4'b0001);
    chk("rr_rv3", r_valid_o, 4'b1000);
    drive(4'b0000, 1'b0, 1'b1, 32'hA4);
    chk("rr_rv0b", r_valid_o, 4'b0001);
    chk("rr_idle_gnt", gnt_o, 0);

    // Stall holds priority on requester 1
    for (int c = 0; c < 3; c++) begin
      drive(4'b0110, 1'b0, 1'b0, 32'h0);
      chk("st_add", m_add_o, addr_of(1));
      chk("st_gnt", gnt_o, 0);
      chk("st_mreq", m_req_o, 1);
    end
    drive(4'b0110, 1'b1, 1'b0, 32'h0);
    chk("st_gnt1", gnt_o, 4'b0010);
    chk("st_add1", m_add_o, addr_of(1));
    drive(4'b0110, 1'b1, 1'b0, 32'h0);
    chk("st_gnt2", gnt_o, 4'b0100);
    chk("st_add2", m_add_o, addr_of(2));

    // Occupancy 2 (ids 1,2): push and pop together
    drive(4'b1111, 1'b1, 1'b1, 32'hB1);
    chk("pp_gnt3", gnt_o, 4'b1000);
    chk("pp_rv1", r_valid_o, 4'b0010);
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    chk("pp_gnt0", gnt_o, 4'b0001);
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    chk("pp_gnt1", gnt_o, 4'b0010);
    chk("pp_mreq", m_req_o, 1);

    // Now full (ids 2,3,0,1): pop cycle still blocks the grant
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    chk("full_mreq", m_req_o, 0);
    chk("full_gnt", gnt_o, 0);
    drive(4'b1111, 1'b1, 1'b1, 32'hC2);
    chk("full_pop_gnt", gnt_o, 0);
    chk("full_pop_mreq", m_req_o, 0);
    chk("full_pop_rv", r_valid_o, 4'b0100);
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    chk("full_resume", gnt_o, 4'b0100);

    // Drain ids 3,0,1,2
    drive(4'b0000, 1'b0, 1'b1, 32'hE3);
    chk("dr_rv3", r_valid_o, 4'b1000);
    chk("dr_rdata3", r_rdata_o[3*DW +: DW], 32'hE3);
    drive(4'b0000, 1'b0, 1'b1, 32'hE0);
    chk("dr_rv0", r_valid_o, 4'b0001);
    drive(4'b0000, 1'b0, 1'b1, 32'hE1);
    chk("dr_rv1", r_valid_o, 4'b0010);
    drive(4'b0000, 1'b0, 1'b1, 32'hE2);
    chk("dr_rv2", r_valid_o, 4'b0100);
    chk("dr_err", err_o, 0);

    // Stray response on an empty FIFO
    drive(4'b0000, 1'b0, 1'b1, 32'hFF);
    chk("stray_rv", r_valid_o, 0);
    chk("stray_err_now", err_o, 0);
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    chk("stray_err", err_o, 1);
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    chk("stray_sticky", err_o, 1);

    // Reset clears err; then ten stalled cycles on requester 0
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b0;
    #1;
    chk("rst2_err", err_o, 0);
    drive(4'b0001, 1'b0, 1'b0, 32'h0);
    chk("sc_add", m_add_o, addr_of(0));
    repeat (10) @(negedge clk_i);
    req_i = 4'b0000;
    #1;
`ifdef HWPE_TCDM_ARB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, 16'd10);
`else
    chk("stall_cnt", stall_cnt_o, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
